// File: rtl/sram16_responder.sv
// RAM-side responder for the MIPS controller's 16-bit external SRAM port: byte-masked
// writes, fixed-latency reads on the shared tri-state bus, protocol-error flags and counters.
module sram16_responder #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 10,
    parameter int RD_LAT  = 1    // legal 1..3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  addr,
    inout  wire logic [DATA_W-1:0] data,
    input  logic               wre,
    input  logic               oute,
    input  logic               hb_mask,
    input  logic               lb_mask,
    input  logic               chip_en,
    input  logic [DEPTH_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               err_contention,
    output logic               err_range,
    output logic [15:0]        wr_count,
    output logic [15:0]        rd_count
);
    localparam int LANE_W = DATA_W / 2;
    localparam int WORDS  = 1 << DEPTH_W;

    typedef struct packed {
        logic              valid;
        logic              hb_n;
        logic              lb_n;
        logic [DATA_W-1:0] word;
    } rd_entry_t;

    logic [DATA_W-1:0]  mem [WORDS];
    // Stage 0 captures the array word at the request edge; stage RD_LAT drives the bus.
    rd_entry_t          pipe [RD_LAT+1];
    rd_entry_t          head;
    logic [DEPTH_W-1:0] index;
    logic               wr_acc;
    logic               rd_acc;
    logic               out_of_range;
    logic               pending;
    logic               bus_read;
    logic               drive_hi;
    logic               drive_lo;

    assign index        = addr[DEPTH_W-1:0];
    assign wr_acc       = !chip_en && !wre;
    assign rd_acc       = !chip_en && wre && !oute;
    assign out_of_range = |addr[ADDR_W-1:DEPTH_W];

    // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            pending = pending | pipe[i].valid;
        end
    end

    // NOTE: the array is deliberately left out of reset; contents persist across reset.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            if (!hb_mask) mem[index][DATA_W-1:LANE_W] <= data[DATA_W-1:LANE_W];
            if (!lb_mask) mem[index][LANE_W-1:0]      <= data[LANE_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
        end else if (wr_acc) begin
            // A write flushes every pending read; the bus now belongs to the controller.
            for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {rd_acc, hb_mask, lb_mask, mem[index]};
            for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_contention <= 1'b0;
            err_range      <= 1'b0;
            wr_count       <= 16'd0;
            rd_count       <= 16'd0;
        end else begin
            if (wr_acc && pending)                   err_contention <= 1'b1;
            if ((wr_acc || rd_acc) && out_of_range)  err_range      <= 1'b1;
            if (wr_acc && wr_count != 16'hFFFF)      wr_count       <= wr_count + 16'd1;
            if (rd_acc && rd_count != 16'hFFFF)      rd_count       <= rd_count + 16'd1;
        end
    end

    // Drive enable follows the live controls so the bus is released the cycle wre falls.
    assign head     = pipe[RD_LAT];
    assign bus_read = !chip_en && !oute && wre;
    assign drive_hi = head.valid && !head.hb_n && bus_read;
    assign drive_lo = head.valid && !head.lb_n && bus_read;

    assign data[DATA_W-1:LANE_W] = drive_hi ? head.word[DATA_W-1:LANE_W] : {LANE_W{1'bz}};
    assign data[LANE_W-1:0]      = drive_lo ? head.word[LANE_W-1:0]      : {LANE_W{1'bz}};

    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_sram16_responder.sv
// Bench for sram16_responder: three instances (RD_LAT 1..3) share the controller signals,
// each with its own pulled-up bus; a queue-based timing model predicts every bus cycle.
module tb_sram16_responder;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int DEPTH_W = 10;

    logic               clock    = 1'b0;
    logic               reset    = 1'b1;
    logic [ADDR_W-1:0]  addr     = '0;
    logic               wre      = 1'b1;
    logic               oute     = 1'b1;
    logic               hb_mask  = 1'b1;
    logic               lb_mask  = 1'b1;
    logic               chip_en  = 1'b1;
    logic [DEPTH_W-1:0] dbg_addr = '0;
    logic [15:0]        wdata    = '0;
    logic               drive_en = 1'b0;

    wire  [15:0] bus1, bus2, bus3;
    logic [15:0] dbg_d [3];
    logic [15:0] wc    [3];
    logic [15:0] rc    [3];
    logic        ec    [3];
    logic        er    [3];

    assign bus1 = drive_en ? wdata : 16'hzzzz;
    assign bus2 = drive_en ? wdata : 16'hzzzz;
    assign bus3 = drive_en ? wdata : 16'hzzzz;

    // Released lanes read back as all-ones.
    for (genvar b = 0; b < 16; b++) begin : g_pull
        pullup (bus1[b]);
        pullup (bus2[b]);
        pullup (bus3[b]);
    end

    always #5 clock = ~clock;

    sram16_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .RD_LAT(1)) u_lat1 (
        .clock(clock), .reset(reset), .addr(addr), .data(bus1), .wre(wre), .oute(oute),
        .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en), .dbg_addr(dbg_addr),
        .dbg_data(dbg_d[0]), .err_contention(ec[0]), .err_range(er[0]),
        .wr_count(wc[0]), .rd_count(rc[0]));

    sram16_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .RD_LAT(2)) u_lat2 (
        .clock(clock), .reset(reset), .addr(addr), .data(bus2), .wre(wre), .oute(oute),
        .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en), .dbg_addr(dbg_addr),
        .dbg_data(dbg_d[1]), .err_contention(ec[1]), .err_range(er[1]),
        .wr_count(wc[1]), .rd_count(rc[1]));

    sram16_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .RD_LAT(3)) u_lat3 (
        .clock(clock), .reset(reset), .addr(addr), .data(bus3), .wre(wre), .oute(oute),
        .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en), .dbg_addr(dbg_addr),
        .dbg_data(dbg_d[2]), .err_contention(ec[2]), .err_range(er[2]),
        .wr_count(wc[2]), .rd_count(rc[2]));

    // Reference model: a read launched at edge k owns the bus between edges k+L and k+L+1.
    typedef struct {
        int          k;
        logic [15:0] d;
        logic        hb_n;
        logic        lb_n;
    } pend_t;

    pend_t       pq [3][$];
    logic [15:0] ref_mem [1024];
    int          ref_wr;
    int          ref_rd;
    bit          ref_erange;
    bit          ref_econt [3];
    int          edge_n;
    int          n_checks;
    int          n_errors;

    task automatic ref_reset();
        for (int l = 0; l < 3; l++) begin
            pq[l].delete();
            ref_econt[l] = 1'b0;
        end
        ref_wr     = 0;
        ref_rd     = 0;
        ref_erange = 1'b0;
    endtask

    task automatic model_edge();
        int idx;
        edge_n++;
        for (int l = 0; l < 3; l++) begin
            while (pq[l].size() != 0 && pq[l][0].k + (l + 1) + 1 <= edge_n) void'(pq[l].pop_front());
        end
        if (!chip_en) begin
            idx = int'(addr[9:0]);
            if (!wre || !oute) begin
                if (addr[17:10] != 8'd0) ref_erange = 1'b1;
            end
            if (!wre) begin
                for (int l = 0; l < 3; l++) begin
                    if (pq[l].size() != 0) ref_econt[l] = 1'b1;
                    pq[l].delete();
                end
                if (!hb_mask) ref_mem[idx][15:8] = wdata[15:8];
                if (!lb_mask) ref_mem[idx][7:0]  = wdata[7:0];
                if (ref_wr < 65535) ref_wr++;
            end else if (!oute) begin
                for (int l = 0; l < 3; l++) pq[l].push_back('{edge_n, ref_mem[idx], hb_mask, lb_mask});
                if (ref_rd < 65535) ref_rd++;
            end
        end
    endtask

    function automatic logic [15:0] exp_bus(int l);
        logic [15:0] e;
        e = 16'hFFFF;
        if (drive_en) return wdata;
        if (!chip_en && !oute && wre) begin
            for (int j = 0; j < pq[l-1].size(); j++) begin
                if (pq[l-1][j].k + l == edge_n) begin
                    if (!pq[l-1][j].hb_n) e[15:8] = pq[l-1][j].d[15:8];
                    if (!pq[l-1][j].lb_n) e[7:0]  = pq[l-1][j].d[7:0];
                end
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] bus_of(int l);
        case (l)
            1:       return bus1;
            2:       return bus2;
            default: return bus3;
        endcase
    endfunction

    // One controller cycle: compare all buses mid-cycle, then let the edge sample the request.
    task automatic tick();
        @(negedge clock);
        for (int l = 1; l <= 3; l++) begin
            n_checks++;
            if (bus_of(l) !== exp_bus(l)) begin
                n_errors++;
                $display("FAIL bus_lat%0d after edge %0d: observed %h expected %h",
                         l, edge_n, bus_of(l), exp_bus(l));
            end
        end
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic req_write(logic [17:0] a, logic [15:0] d, logic hb, logic lb);
        chip_en = 1'b0; wre = 1'b0; oute = 1'b1; hb_mask = hb; lb_mask = lb;
        addr = a; wdata = d; drive_en = 1'b1;
    endtask

    task automatic req_read(logic [17:0] a, logic hb, logic lb);
        chip_en = 1'b0; wre = 1'b1; oute = 1'b0; hb_mask = hb; lb_mask = lb;
        addr = a; drive_en = 1'b0;
    endtask

    task automatic req_idle();
        chip_en = 1'b1; wre = 1'b1; oute = 1'b1; hb_mask = 1'b1; lb_mask = 1'b1; drive_en = 1'b0;
    endtask

    task automatic idle(int n);
        req_idle();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        req_idle();
        #2 reset = 1'b0;
        ref_reset();
        #3;
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (bus_of(l + 1) !== 16'hFFFF || wc[l] !== 16'd0 || rc[l] !== 16'd0 ||
                ec[l] !== 1'b0 || er[l] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state lat%0d: bus %h wr %0d rd %0d econt %b erange %b, expected ffff 0 0 0 0",
                         l + 1, bus_of(l + 1), wc[l], rc[l], ec[l], er[l]);
            end
        end
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        idle(2);
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (wc[l] !== 16'd0 || rc[l] !== 16'd0) begin
                n_errors++;
                $display("FAIL idle_counts lat%0d: wr %0d rd %0d expected 0 0", l + 1, wc[l], rc[l]);
            end
        end
    endtask

    task automatic test_basic();
        req_write(18'd5, 16'hBEEF, 1'b0, 1'b0);
        tick();
        req_read(18'd5, 1'b0, 1'b0);
        tick();
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (wc[l] !== 16'd1 || rc[l] !== 16'd1) begin
                n_errors++;
                $display("FAIL basic_counts lat%0d: wr %0d rd %0d expected 1 1", l + 1, wc[l], rc[l]);
            end
        end
        req_read(18'd5, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus1 !== 16'hBEEF || bus2 !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL basic_read: lat1 %h lat2 %h expected beef ffff", bus1, bus2);
        end
        idle(4);
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (ec[l] !== 1'b0 || er[l] !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_errors lat%0d: econt %b erange %b expected 0 0", l + 1, ec[l], er[l]);
            end
        end
    endtask

    task automatic test_byte_masks();
        req_write(18'd7, 16'h1234, 1'b0, 1'b0);
        tick();
        req_write(18'd7, 16'hAB00, 1'b0, 1'b1);
        tick();
        req_read(18'd7, 1'b0, 1'b0);
        tick();
        req_read(18'd7, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus1 !== 16'hAB34) begin
            n_errors++;
            $display("FAIL mask_merge: observed %h expected ab34", bus1);
        end
        req_read(18'd7, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus1[15:8] !== 8'hFF || bus1[7:0] !== 8'h34 || bus2 !== 16'hAB34) begin
            n_errors++;
            $display("FAIL mask_lane: lat1 %h lat2 %h expected ff34(upper released) ab34", bus1, bus2);
        end
        idle(4);
    endtask

    task automatic test_streaming();
        logic [15:0] want;
        for (int i = 0; i < 8; i++) begin
            want = 16'h0101 * 16'(i);
            req_write(18'(i), want, 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j < 12; j++) begin
            req_read(18'(j < 8 ? j : 0), 1'b0, 1'b0);
            tick();
            if (j >= 3 && j <= 10) begin
                want = 16'h0101 * 16'(j - 3);
                n_checks++;
                if (bus3 !== want) begin
                    n_errors++;
                    $display("FAIL stream_lat3 beat %0d: observed %h expected %h", j - 3, bus3, want);
                end
            end
        end
        idle(4);
    endtask

    task automatic test_contention();
        req_read(18'd1, 1'b0, 1'b0);
        tick();
        req_write(18'd9, 16'h0909, 1'b0, 1'b0);
        tick();
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (ec[l] !== 1'b1) begin
                n_errors++;
                $display("FAIL contention_flag lat%0d: observed %b expected 1", l + 1, ec[l]);
            end
        end
        req_read(18'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus2 !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL contention_drop lat2: observed %h expected ffff", bus2);
        end
        tick();
        n_checks++;
        if (bus3 !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL contention_drop lat3: observed %h expected ffff", bus3);
        end
        idle(4);
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (ec[l] !== 1'b1) begin
                n_errors++;
                $display("FAIL contention_sticky lat%0d: observed %b expected 1", l + 1, ec[l]);
            end
        end
    endtask

    task automatic test_alias_range();
        n_checks++;
        if (er[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL range_before: observed %b expected 0", er[0]);
        end
        req_write(18'h00400, 16'h5A5A, 1'b0, 1'b0);
        tick();
        idle(1);
        dbg_addr = '0;
        #1;
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (dbg_d[l] !== 16'h5A5A || er[l] !== 1'b1) begin
                n_errors++;
                $display("FAIL alias_range lat%0d: dbg %h erange %b expected 5a5a 1", l + 1, dbg_d[l], er[l]);
            end
        end
    endtask

    task automatic test_reset_pending();
        req_read(18'd0, 1'b0, 1'b0);
        tick();
        req_idle();
        tick();
        tick();
        req_read(18'd0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus2 !== 16'h5A5A || bus3 !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL pre_reset: lat2 %h lat3 %h expected 5a5a ffff", bus2, bus3);
        end
        reset = 1'b0;
        ref_reset();
        #1;
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (bus_of(l + 1) !== 16'hFFFF || wc[l] !== 16'd0 || rc[l] !== 16'd0 ||
                ec[l] !== 1'b0 || er[l] !== 1'b0) begin
                n_errors++;
                $display("FAIL async_reset lat%0d: bus %h wr %0d rd %0d econt %b erange %b, expected ffff 0 0 0 0",
                         l + 1, bus_of(l + 1), wc[l], rc[l], ec[l], er[l]);
            end
        end
        reset = 1'b1;
        #1;
        for (int l = 1; l <= 3; l++) begin
            n_checks++;
            if (bus_of(l) !== 16'hFFFF) begin
                n_errors++;
                $display("FAIL post_release lat%0d: observed %h expected ffff", l, bus_of(l));
            end
        end
        repeat (4) tick();
        dbg_addr = '0;
        #1;
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (dbg_d[l] !== 16'h5A5A) begin
                n_errors++;
                $display("FAIL array_retained lat%0d: observed %h expected 5a5a", l + 1, dbg_d[l]);
            end
        end
        idle(4);
    endtask

    task automatic test_random();
        logic [17:0] a;
        for (int i = 0; i < 32; i++) begin
            req_write(18'(i), 16'($urandom), 1'b0, 1'b0);
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            a = 18'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) a[17:10] = 8'($urandom_range(1, 255));
            if (r < 2) begin
                req_idle();
            end else if (r < 5) begin
                req_write(a, 16'($urandom), 1'($urandom), 1'($urandom));
            end else if (r < 9) begin
                req_read(a, 1'($urandom), 1'($urandom));
            end else begin
                req_read(a, 1'($urandom), 1'($urandom));
                oute = 1'b1;
            end
            tick();
        end
        idle(4);
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (wc[l] !== 16'(ref_wr) || rc[l] !== 16'(ref_rd) ||
                ec[l] !== ref_econt[l] || er[l] !== ref_erange) begin
                n_errors++;
                $display("FAIL random_status lat%0d: wr %0d rd %0d econt %b erange %b, expected %0d %0d %b %b",
                         l + 1, wc[l], rc[l], ec[l], er[l], ref_wr, ref_rd, ref_econt[l], ref_erange);
            end
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 10'(i);
            #1;
            n_checks++;
            if (dbg_d[0] !== ref_mem[i] || dbg_d[2] !== ref_mem[i]) begin
                n_errors++;
                $display("FAIL random_array word %0d: lat1 %h lat3 %h expected %h",
                         i, dbg_d[0], dbg_d[2], ref_mem[i]);
            end
        end
    endtask

    task automatic test_saturation();
        req_write(18'd3, 16'h3333, 1'b0, 1'b0);
        while (ref_wr < 65534) begin
            @(posedge clock);
            model_edge();
        end
        #1;
        n_checks++;
        if (wc[1] !== 16'hFFFE) begin
            n_errors++;
            $display("FAIL wr_count_near_sat: observed %h expected fffe", wc[1]);
        end
        repeat (3) begin
            @(posedge clock);
            model_edge();
        end
        #1;
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (wc[l] !== 16'hFFFF || rc[l] !== 16'(ref_rd)) begin
                n_errors++;
                $display("FAIL wr_count_sat lat%0d: wr %h rd %0d expected ffff %0d", l + 1, wc[l], rc[l], ref_rd);
            end
        end
        idle(2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_n   = 0;
        ref_reset();
        test_reset();
        test_basic();
        test_byte_masks();
        test_streaming();
        test_contention();
        test_alias_range();
        test_reset_pending();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram16_responder.md
# sram16_responder

Synthesizable responder for the 16-bit external SRAM port driven by the MIPS memory controller (addr/data/wre/oute/hb_mask/lb_mask/chip_en). It occupies the RAM end of that interface: it samples controller requests on the fast memory clock, stores byte-masked writes, and returns reads on the shared tri-state bus after a fixed, configurable latency. It replaces the board SRAM in simulation and FPGA bring-up, and reports bus-protocol errors and access statistics.

## Interface
- ADDR_W, 18, address width of the RAM port.
- DATA_W, 16, data bus width; two byte lanes, fixed.
- DEPTH_W, 10, log2 of implemented words; address aliases modulo 2^DEPTH_W.
- RD_LAT, 1, read latency in cycles, legal 1..3.
- clock  in  1  memory clock (the controller's fast clock); rising edge.
- reset  in  1  asynchronous, active-low.
- addr  in  ADDR_W  word address.
- data  inout  DATA_W  shared bus; driven by responder only for read data, else Z.
- wre  in  1  write enable, active-low.
- oute  in  1  output enable, active-low.
- hb_mask  in  1  upper byte lane enable [15:8], active-low.
- lb_mask  in  1  lower byte lane enable [7:0], active-low.
- chip_en  in  1  chip select, active-low.
- dbg_addr  in  DEPTH_W  backdoor read address.
- dbg_data  out  DATA_W  combinational array[dbg_addr].
- err_contention  out  1  sticky: write issued while read data pending.
- err_range  out  1  sticky: access with addr bits above DEPTH_W nonzero.
- wr_count  out  16  accepted writes, saturating.
- rd_count  out  16  accepted reads, saturating.

## Operation
- Request sampled each rising edge when chip_en=0; chip_en=1 is idle, no state change except pipeline advance.
- Write (wre=0): array[addr[DEPTH_W-1:0]] lane [15:8] updated if hb_mask=0, lane [7:0] if lb_mask=0; both masks high = write counted, no data change. data sampled at that edge.
- Read (wre=1, oute=0): launches entry {valid, index, lane masks} into RD_LAT-deep shift pipeline; array read at the stage-0 capture, so data reflects all writes sampled at earlier edges.
- wre=1, oute=1: no access, not counted.
- Output stage: bus lane driven when head entry valid AND lane mask was low at launch AND current chip_en=0, oute=0, wre=1; otherwise lane is Z. Drive enable combinational on current controls so the responder releases the bus in the same cycle the controller asserts wre.
- Write sampled while any pipeline entry valid: all pending entries dropped, err_contention set.
- err_range set on any accepted access with addr[ADDR_W-1:DEPTH_W] != 0; access still performed on aliased index.
- Counters increment per accepted access, saturate at 16'hFFFF.
- Array contents not affected by reset; undefined until written.

## Timing
- Reset (reset=0, async): pipeline cleared, data Z immediately, err_* = 0, wr_count = rd_count = 0.
- Reset released mid-operation: no pending read survives; first request sampled on first rising edge with reset=1.
- Read sampled at edge k: data valid on bus from edge k+RD_LAT to edge k+RD_LAT+1; controller samples at edge k+RD_LAT+1.
- Back-to-back reads: one per cycle, data in order, no bubbles.
- Write at edge k, read same address at edge k+1: returns new data.
- Write and read are exclusive per edge (wre selects); no same-edge collision.

## Test plan
- Reset then idle: data=Z, counters 0, errors 0; write 16'hBEEF to addr 5 with both masks low, read addr 5 with RD_LAT=1 -> 16'hBEEF on bus between edges k+1 and k+2, wr_count=1, rd_count=1.
- Byte masks: write 16'h1234 to addr 7, then write 16'hAB00 with hb_mask=0, lb_mask=1 -> read returns 16'hAB34; read with hb_mask=1 -> lane [15:8] Z, [7:0]=8'h34.
- Streaming: RD_LAT=3, write addrs 0..7 with value addr*16'h0101, then 8 consecutive reads -> data stream 16'h0000..16'h0707 in order, first valid at edge k+3.
- Contention: RD_LAT=2, read addr 1 then write at next edge -> bus Z from that cycle, pending read dropped, err_contention=1 until reset.
- Aliasing/range: DEPTH_W=10, write 16'h5A5A to addr 18'h00400 -> dbg_addr=0 shows 16'h5A5A, err_range=1.
- Async reset during pending RD_LAT=3 read -> bus Z immediately, no data after release, array retains 16'h5A5A at index 0.
